// File: rtl/wb_trace_buffer_pkg.sv
// Shared types for the write-back trace buffer: FSM state encoding.
// The entry layout is parameter-dependent, so it is declared in the top.
package wb_trace_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_e;

endpackage

// File: rtl/wb_trace_buffer_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// The read register holds its value between reads and resets to zero.
module wb_trace_ram #(
  parameter int W     = 37,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace capture with arm/trigger/freeze control and pop readout.
// Define WB_TRACE_TIMESTAMP_EN to store a cycle timestamp per entry (rd_ts).
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 8,
  parameter int TS_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic                     wrap_mode,
  input  logic                     trig_en,
  input  logic [DATA_W-1:0]        trig_value,
  input  logic                     wb_vld,
  input  logic [REG_W-1:0]         wb_reg,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rd_req,
  output logic                     rd_vld,
  output logic [REG_W-1:0]         rd_reg,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [STATE_W-1:0]       state,
  output logic                     overflow,
  output logic                     triggered
`ifdef WB_TRACE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]          rd_ts
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 4");
  end
  if (POST_TRIG < 0 || POST_TRIG >= DEPTH) begin : g_bad_post
    $error("POST_TRIG must be in 0..DEPTH-1");
  end
  if (TS_W < 1) begin : g_bad_ts
    $error("TS_W must be at least 1");
  end

  typedef struct packed {
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
    logic [REG_W-1:0]  rix;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e           st_q, st_d;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, post_cnt;
  logic [CNT_W-1:0] cnt;
  logic             capture, full, do_write, trig_hit, post_done, rd_fire;
  entry_t           wr_ent, rd_ent;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  // FSM: next state; arm beats disarm beats trigger/post completion
  always_comb begin
    st_d = st_q;
    if (arm)                                st_d = ST_ARMED;
    else if (disarm && st_q != ST_FROZEN)   st_d = ST_FROZEN;
    else begin
      case (st_q)
        ST_ARMED: if (trig_hit)  st_d = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
        ST_POST:  if (post_done) st_d = ST_FROZEN;
        default:  ;
      endcase
    end
  end

  // FSM: decoded enables
  always_comb begin
    capture   = (st_q == ST_ARMED || st_q == ST_POST) && wb_vld && !arm && !disarm;
    full      = (cnt == CNT_W'(DEPTH));
    do_write  = capture && (!full || wrap_mode);
    trig_hit  = (st_q == ST_ARMED) && capture && trig_en && (wb_data == trig_value);
    post_done = (st_q == ST_POST) && capture && (post_cnt == PTR_W'(1));
    rd_fire   = (st_q == ST_FROZEN) && rd_req && (cnt != '0) && !arm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      post_cnt  <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
      rd_vld    <= 1'b0;
    end else begin
      rd_vld <= rd_fire;
      if (arm) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        cnt       <= '0;
        overflow  <= 1'b0;
        triggered <= 1'b0;
      end else begin
        // wrap overwrite advances the read pointer past the lost oldest entry
        if (do_write) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (full) rd_ptr <= rd_ptr + 1'b1;
          else      cnt    <= cnt + 1'b1;
        end
        if (capture && full) overflow <= 1'b1;
        if (rd_fire) begin
          rd_ptr <= rd_ptr + 1'b1;
          cnt    <= cnt - 1'b1;
        end
        if (trig_hit) begin
          triggered <= 1'b1;
          post_cnt  <= PTR_W'(POST_TRIG);
        end else if (st_q == ST_POST && capture) begin
          post_cnt  <= post_cnt - 1'b1;
        end
      end
    end
  end

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ts_q <= '0;
    else if (arm) ts_q <= '0;
    else          ts_q <= ts_q + 1'b1;
  end

  assign wr_ent.ts = ts_q;
  assign rd_ts     = rd_ent.ts;
`endif

  assign wr_ent.rix  = wb_reg;
  assign wr_ent.data = wb_data;

  wb_trace_ram #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata (wr_ent),
    .re    (rd_fire),
    .raddr (rd_ptr),
    .rdata (rd_ent)
  );

  assign rd_reg  = rd_ent.rix;
  assign rd_data = rd_ent.data;
  assign count   = cnt;
  assign state   = st_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scenario bench for wb_trace_buffer: expected entries are queued as stimulus
// is driven and popped when the buffer is drained.
module tb_wb_trace_buffer;

  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;
  localparam int DEPTH     = 64;
  localparam int POST_TRIG = 8;
  localparam int TS_W      = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0, disarm = 1'b0, wrap_mode = 1'b0, trig_en = 1'b0;
  logic [DATA_W-1:0] trig_value = '0;
  logic              wb_vld = 1'b0;
  logic [REG_W-1:0]  wb_reg = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              rd_req = 1'b0;
  logic              rd_vld;
  logic [REG_W-1:0]  rd_reg;
  logic [DATA_W-1:0] rd_data;
  logic [$clog2(DEPTH):0] count;
  logic [1:0]        state;
  logic              overflow, triggered;
`ifdef WB_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]   rd_ts;
`endif

  typedef struct {
    logic [REG_W-1:0]  r;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(
    .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .wrap_mode(wrap_mode),
    .trig_en(trig_en), .trig_value(trig_value), .wb_vld(wb_vld), .wb_reg(wb_reg),
    .wb_data(wb_data), .rd_req(rd_req), .rd_vld(rd_vld), .rd_reg(rd_reg),
    .rd_data(rd_data), .count(count), .state(state), .overflow(overflow),
    .triggered(triggered)
`ifdef WB_TRACE_TIMESTAMP_EN
    , .rd_ts(rd_ts)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
    wb_vld = 1'b1; wb_reg = r; wb_data = d;
    tick();
    wb_vld = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm = 1'b1; tick(); disarm = 1'b0;
  endtask

  task automatic push(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
    exp_t e;
    e.r = r; e.d = d;
    exp_q.push_back(e);
  endtask

  // Back-to-back pops of every queued entry, then one extra request on empty.
  task automatic drain(input string tag);
    int n = exp_q.size();
    rd_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      tick();
      e = exp_q.pop_front();
      checks++;
      if (rd_vld !== 1'b1 || rd_reg !== e.r || rd_data !== e.d) begin
        errors++;
        $display("FAIL %s pop%0d: got vld=%b reg=%0d data=%h, want vld=1 reg=%0d data=%h",
                 tag, i, rd_vld, rd_reg, rd_data, e.r, e.d);
      end
    end
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s empty_pop: got rd_vld=%b, want 0", tag, rd_vld);
    end
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL %s count_after_drain: got %0d, want 0", tag, count);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (state !== 2'd0 || count !== '0 || rd_vld !== 1'b0 || rd_reg !== '0 ||
        rd_data !== '0 || overflow !== 1'b0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL reset: got state=%0d count=%0d vld=%b reg=%0d data=%h ovf=%b trg=%b, want all 0",
               state, count, rd_vld, rd_reg, rd_data, overflow, triggered);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    pulse_arm();
    wb_write(5'd1, 32'h11); push(5'd1, 32'h11);
    wb_write(5'd2, 32'h22); push(5'd2, 32'h22);
    wb_write(5'd3, 32'h33); push(5'd3, 32'h33);
    pulse_disarm();
    checks++;
    if (count !== 7'd3 || state !== 2'd3) begin
      errors++;
      $display("FAIL basic_frozen: got count=%0d state=%0d, want count=3 state=3", count, state);
    end
    drain("basic");
  endtask

  task automatic test_fill(input logic wrap);
    wrap_mode = wrap;
    pulse_arm();
    for (int i = 0; i < 70; i++) begin
      wb_write(REG_W'(i), DATA_W'(i));
      if (exp_q.size() < DEPTH) push(REG_W'(i), DATA_W'(i));
      else if (wrap) begin
        void'(exp_q.pop_front());
        push(REG_W'(i), DATA_W'(i));
      end
    end
    pulse_disarm();
    checks++;
    if (count !== 7'd64 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fill_wrap%0b: got count=%0d ovf=%b, want count=64 ovf=1", wrap, count, overflow);
    end
    drain(wrap ? "wrap" : "nowrap");
    wrap_mode = 1'b0;
  endtask

  task automatic test_trigger();
    trig_en = 1'b1; trig_value = 32'hDEAD;
    pulse_arm();
    for (int i = 0; i < 10; i++) begin
      wb_write(5'd4, DATA_W'(i)); push(5'd4, DATA_W'(i));
    end
    wb_write(5'd9, 32'hDEAD); push(5'd9, 32'hDEAD);
    checks++;
    if (state !== 2'd2 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL trig_fire: got state=%0d trg=%b, want state=2 trg=1", state, triggered);
    end
    for (int v = 100; v <= 120; v++) begin
      wb_write(5'd6, DATA_W'(v));
      if (v <= 107) push(5'd6, DATA_W'(v));
      if (v == 106) begin
        checks++;
        if (state !== 2'd2) begin
          errors++;
          $display("FAIL trig_post106: got state=%0d, want 2", state);
        end
      end
      if (v == 107) begin
        checks++;
        if (state !== 2'd3) begin
          errors++;
          $display("FAIL trig_frozen107: got state=%0d, want 3", state);
        end
      end
    end
    checks++;
    if (count !== 7'd19 || triggered !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL trig_count: got count=%0d trg=%b ovf=%b, want 19 1 0", count, triggered, overflow);
    end
    drain("trigger");
  endtask

  task automatic test_async_reset();
    pulse_arm();
    wb_write(5'd1, 32'hDEAD);
    wb_write(5'd2, 32'h1);
    wb_write(5'd3, 32'h2);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL areset_pre: got state=%0d, want 2", state);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || count !== '0 || rd_vld !== 1'b0 || rd_reg !== '0 ||
        rd_data !== '0 || overflow !== 1'b0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL areset: got state=%0d count=%0d vld=%b reg=%0d data=%h ovf=%b trg=%b, want all 0",
               state, count, rd_vld, rd_reg, rd_data, overflow, triggered);
    end
    #2 rst_n = 1'b1;
    tick();
    rd_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (rd_vld !== 1'b0 || state !== 2'd0) begin
        errors++;
        $display("FAIL areset_idle_read%0d: got vld=%b state=%0d, want 0 0", i, rd_vld, state);
      end
    end
    rd_req = 1'b0;
    trig_en = 1'b0;
  endtask

  task automatic test_arm_same_cycle();
    logic [TS_W-1:0] ts0;
    ts0 = '0;
    arm = 1'b1; wb_vld = 1'b1; wb_reg = 5'd7; wb_data = 32'h55;
    tick();
    arm = 1'b0; wb_vld = 1'b0;
    checks++;
    if (count !== '0 || state !== 2'd1) begin
      errors++;
      $display("FAIL arm_same_cycle: got count=%0d state=%0d, want 0 1", count, state);
    end
    wb_write(5'd10, 32'hA1);
    tick(); tick();
    wb_write(5'd11, 32'hA2);
    pulse_disarm();
    rd_req = 1'b1;
    tick();
    checks++;
    if (rd_vld !== 1'b1 || rd_reg !== 5'd10 || rd_data !== 32'hA1) begin
      errors++;
      $display("FAIL ts_pop0: got vld=%b reg=%0d data=%h, want 1 10 a1", rd_vld, rd_reg, rd_data);
    end
`ifdef WB_TRACE_TIMESTAMP_EN
    ts0 = rd_ts;
`endif
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_vld !== 1'b1 || rd_reg !== 5'd11 || rd_data !== 32'hA2) begin
      errors++;
      $display("FAIL ts_pop1: got vld=%b reg=%0d data=%h, want 1 11 a2", rd_vld, rd_reg, rd_data);
    end
`ifdef WB_TRACE_TIMESTAMP_EN
    checks++;
    if (rd_ts - ts0 !== TS_W'(3)) begin
      errors++;
      $display("FAIL ts_delta: got %0d, want 3", rd_ts - ts0);
    end
`endif
    tick();
    checks++;
    if (rd_vld !== 1'b0 || rd_data !== 32'hA2 || count !== '0) begin
      errors++;
      $display("FAIL hold_after_read: got vld=%b data=%h count=%0d, want 0 a2 0", rd_vld, rd_data, count);
    end
    if (ts0 == '1) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill(1'b0);
    test_fill(1'b1);
    test_trigger();
    test_async_reset();
    test_arm_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
